sobel_gradient: RTL and testbench
=================================

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter PICTURE_LENGTH, default 200, rows per frame.
REQ-003 SHALL have parameter PICTURE_WIDTH, default 200, pixels per row.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_pixel  input  DATA_WIDTH, in_valid  input  1, in_ready  output  1: Gaussian-filtered pixel stream, raster order.
REQ-007 SHALL have ports out_mag  output  DATA_WIDTH, out_dir  output  2, out_valid  output  1, out_ready  input  1, out_last  output  1: gradient stream, same raster order.

Function
REQ-008 SHALL transfer on in_valid&in_ready (input) and out_valid&out_ready (output) only.
REQ-009 SHALL form a 3x3 window p[r][c] from two line buffers plus the live pixel, centre p11.
REQ-010 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p00+2p01+p02)-(p20+2p21+p22), 11-bit signed, no overflow.
REQ-011 SHALL output out_mag=min(|Gx|+|Gy|,255).
REQ-012 SHALL output out_dir: 0 if 5|Gy|<=2|Gx|; else 2 if 5|Gx|<=2|Gy|; else 1 if sign(Gx)==sign(Gy); else 3.
REQ-013 SHALL output out_mag=0, out_dir=0 for frame-border pixels (row 0, last row, col 0, last col).
REQ-014 SHALL emit exactly PICTURE_LENGTH*PICTURE_WIDTH outputs per frame; out_last high on the final one only.
REQ-015 SHALL use FSM FILL->RUN->FLUSH->FILL.
REQ-016 FILL: in_ready=1, no output; leave to RUN after PICTURE_WIDTH+1 inputs accepted.
REQ-017 RUN: each accepted input produces output index k=(input index)-(PICTURE_WIDTH+1), registered, 1-cycle latency; in_ready=!out_valid|out_ready.
REQ-018 FLUSH: entered after last input of frame; in_ready=0; emit remaining PICTURE_WIDTH+1 outputs (bottom row and border), then FILL.
REQ-019 SHALL hold out_mag/out_dir/out_last stable while out_valid&!out_ready.
REQ-020 SHALL wrap column counter at PICTURE_WIDTH and row counter at PICTURE_LENGTH; next frame may start immediately after FLUSH.

Reset
REQ-021 On reset: state=FILL, counters=0, out_valid=0, out_last=0, out_mag=0, out_dir=0, in_ready=0 during reset cycle.
REQ-022 Reset mid-frame SHALL discard partial frame; line-buffer contents not cleared (masked by border rule).

Configuration
REQ-023 SOBEL_DIR_EN defined: out_dir computed per REQ-012.
REQ-024 SOBEL_DIR_EN undefined: out_dir constant 0, comparator logic absent; magnitude path unchanged.

Structure
REQ-025 Package canny_pkg SHALL hold DATA_WIDTH, PICTURE_LENGTH, PICTURE_WIDTH defaults, direction enum (DIR_0, DIR_45, DIR_90, DIR_135), gradient signed type.
REQ-026 Sub-module sobel_line_buf (PICTURE_WIDTH x DATA_WIDTH, single read/write per cycle) SHALL be instantiated twice.

Verification
REQ-027 Flat frame all 100 -> all 40000 outputs mag 0, dir 0, out_last on output 40000.
REQ-028 Vertical step (col<100 ->0, else 200) -> rows 1..198, cols 99,100: mag 255, dir 0; elsewhere 0.
REQ-029 Single 40 at (50,50), rest 0 -> (50,49): mag 80 dir 0; (49,50): mag 80 dir 2; (49,49): mag 80 dir 3; (49,51): mag 80 dir 1.
REQ-030 Random out_ready 30% and random in_valid gaps -> output sequence identical to no-stall run.
REQ-031 Reset asserted at input 15000, then full step frame -> exactly 40000 outputs matching REQ-028.
REQ-032 Two back-to-back frames -> second frame outputs uncorrupted, out_last once per frame.

Source files
------------

// File: rtl/canny_pkg.sv
// canny_pkg: shared defaults, direction encoding and gradient type for the
// Sobel gradient stage of the edge-detection pipeline.
package canny_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int PICTURE_LENGTH_DEF = 200;
    localparam int PICTURE_WIDTH_DEF  = 200;

    // 4 * 255 per component plus sign fits in 11 bits
    localparam int GRAD_WIDTH = DATA_WIDTH_DEF + 3;

    typedef logic signed [GRAD_WIDTH-1:0] grad_t;

    // quantised gradient direction
    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // |g|; the most negative code never occurs, so one bit less suffices
    function automatic logic [GRAD_WIDTH-2:0] abs_grad(input grad_t g);
        logic [GRAD_WIDTH-1:0] t;
        t = g[GRAD_WIDTH-1] ? -g : g;
        return t[GRAD_WIDTH-2:0];
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image row of pixels. Read of the old value and write of
// the new value happen at the same address in the same cycle.
module sobel_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 200,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // write the incoming row pixel over the value just read
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: 3x3 Sobel gradient magnitude (and optionally direction)
// over a raster-order pixel stream with valid/ready on both sides.
// Optional macro SOBEL_DIR_EN: when defined, out_dir carries the quantised
// direction; when undefined out_dir is tied to 0.
module sobel_gradient
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int PICTURE_LENGTH = PICTURE_LENGTH_DEF,
    parameter int PICTURE_WIDTH  = PICTURE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_mag,
    output logic [1:0]            out_dir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CW = (PICTURE_WIDTH  > 1) ? $clog2(PICTURE_WIDTH)  : 1;
    localparam int RW = (PICTURE_LENGTH > 1) ? $clog2(PICTURE_LENGTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PICTURE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PICTURE_LENGTH - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam int AMW = GRAD_WIDTH - 1;
    localparam logic [GRAD_WIDTH-1:0] MAG_MAX = GRAD_WIDTH'((1 << DATA_WIDTH) - 1);

    state_e                state, state_nx;
    logic [CW-1:0]         in_col, out_col;
    logic [RW-1:0]         in_row, out_row;
    logic                  in_fire, out_load, slot_free;
    logic                  in_col_end, in_frame_end, out_col_end, out_frame_end;
    logic                  border;
    logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
    logic [DATA_WIDTH-1:0] p   [3][3];
    logic [DATA_WIDTH-1:0] win [3][2];
    grad_t                 gx, gy;
    logic [AMW-1:0]        ax, ay;
    logic [GRAD_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] mag_nx;
    dir_e                  dir_nx;

    function automatic grad_t px(input logic [DATA_WIDTH-1:0] v);
        return grad_t'({{(GRAD_WIDTH-DATA_WIDTH){1'b0}}, v});
    endfunction

    assign slot_free     = !out_valid || out_ready;
    assign in_fire       = in_valid && in_ready;
    assign in_col_end    = (in_col == COL_LAST);
    assign in_frame_end  = in_col_end && (in_row == ROW_LAST);
    assign out_col_end   = (out_col == COL_LAST);
    assign out_frame_end = out_col_end && (out_row == ROW_LAST);
    assign border        = (out_row == '0) || (out_row == ROW_LAST) ||
                           (out_col == '0) || (out_col == COL_LAST);

    // lb1 holds the previous row, lb2 the row before that
    sobel_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(PICTURE_WIDTH), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (in_fire),
        .addr    (in_col),
        .wr_data (in_pixel),
        .rd_data (lb1_rd)
    );

    sobel_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(PICTURE_WIDTH), .AW(CW)) u_lb2 (
        .clk     (clk),
        .wr_en   (in_fire),
        .addr    (in_col),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    // input handshake: always open while filling, gated by the output slot while running
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_FILL: in_ready = !reset;
            ST_RUN:  in_ready = !reset && slot_free;
            default: in_ready = 1'b0;
        endcase
    end

    // next state and output-register load strobe
    always_comb begin
        state_nx = state;
        out_load = 1'b0;
        case (state)
            ST_FILL: begin
                // the (width+1)-th pixel completes the first usable window
                if (in_fire && in_row == ROW_ONE && in_col == '0) state_nx = ST_RUN;
            end
            ST_RUN: begin
                out_load = in_fire;
                if (in_fire && in_frame_end) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                out_load = slot_free;
                if (slot_free && out_frame_end) state_nx = ST_FILL;
            end
            default: state_nx = ST_FILL;
        endcase
    end

    // window: two registered columns plus the live column (rows r-2, r-1, r)
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win[r][0];
            p[r][1] = win[r][1];
        end
        p[0][2] = lb2_rd;
        p[1][2] = lb1_rd;
        p[2][2] = in_pixel;
    end

    // Sobel kernels and saturated L1 magnitude
    always_comb begin
        gx = (px(p[0][2]) + (px(p[1][2]) <<< 1) + px(p[2][2]))
           - (px(p[0][0]) + (px(p[1][0]) <<< 1) + px(p[2][0]));
        gy = (px(p[0][0]) + (px(p[0][1]) <<< 1) + px(p[0][2]))
           - (px(p[2][0]) + (px(p[2][1]) <<< 1) + px(p[2][2]));
        ax  = abs_grad(gx);
        ay  = abs_grad(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        mag_nx = (sum > MAG_MAX) ? MAG_MAX[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
    end

`ifdef SOBEL_DIR_EN
    localparam int CMPW = GRAD_WIDTH + 2;
    logic [CMPW-1:0] ax2, ay2, ax5, ay5;

    // tan(22.5) ~ 2/5: compare 5|a| against 2|b| instead of dividing
    always_comb begin
        ax2 = CMPW'(ax) << 1;
        ay2 = CMPW'(ay) << 1;
        ax5 = (CMPW'(ax) << 2) + CMPW'(ax);
        ay5 = (CMPW'(ay) << 2) + CMPW'(ay);
        if (ay5 <= ax2)                             dir_nx = DIR_0;
        else if (ax5 <= ay2)                        dir_nx = DIR_90;
        else if (gx[GRAD_WIDTH-1] == gy[GRAD_WIDTH-1]) dir_nx = DIR_45;
        else                                        dir_nx = DIR_135;
    end
`else
    assign dir_nx = DIR_0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= state_nx;
    end

    // raster position of the next accepted input pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            in_col <= '0;
            in_row <= '0;
        end else if (in_fire) begin
            in_col <= in_col_end ? '0 : in_col + 1'b1;
            if (in_col_end) in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end
    end

    // raster position of the next output to be loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            out_col <= '0;
            out_row <= '0;
        end else if (out_load) begin
            out_col <= out_col_end ? '0 : out_col + 1'b1;
            if (out_col_end) out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end
    end

    // slide the registered window columns on each accepted pixel
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= p[r][2];
            end
        end
    end

    // output register; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_dir   <= DIR_0;
            out_last  <= 1'b0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_mag   <= border ? '0 : mag_nx;
            out_dir   <= border ? DIR_0 : dir_nx;
            out_last  <= out_frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: randomized stream bench for sobel_gradient on a reduced
// frame size, checked against a per-pixel image-domain Sobel model.
module tb_sobel_gradient;

    localparam int DW   = 8;
    localparam int L    = 14;
    localparam int W    = 18;
    localparam int NPX  = L * W;
    localparam int MAXF = 2;
    localparam int IR   = 6;
    localparam int IC   = 7;
`ifdef SOBEL_DIR_EN
    localparam int DEN  = 1;
`else
    localparam int DEN  = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_pixel;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_mag;
    logic [1:0]    out_dir;
    logic          out_valid, out_ready, out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int img     [MAXF][L][W];
    int cap_mag [MAXF][NPX];
    int cap_dir [MAXF][NPX];

    always #5 clk = ~clk;

    sobel_gradient #(.DATA_WIDTH(DW), .PICTURE_LENGTH(L), .PICTURE_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_mag   (out_mag),
        .out_dir   (out_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sobel on the whole image, straight from the kernel definitions
    function automatic void ref_px(input int f, input int r, input int c,
                                   output int mag, output int dir);
        int gx, gy, ax, ay;
        mag = 0;
        dir = 0;
        if (r == 0 || r == L-1 || c == 0 || c == W-1) return;
        gx = (img[f][r-1][c+1] + 2*img[f][r][c+1] + img[f][r+1][c+1])
           - (img[f][r-1][c-1] + 2*img[f][r][c-1] + img[f][r+1][c-1]);
        gy = (img[f][r-1][c-1] + 2*img[f][r-1][c] + img[f][r-1][c+1])
           - (img[f][r+1][c-1] + 2*img[f][r+1][c] + img[f][r+1][c+1]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        mag = (ax + ay > 255) ? 255 : ax + ay;
        if (DEN != 0) begin
            if (5*ay <= 2*ax)             dir = 0;
            else if (5*ax <= 2*ay)        dir = 2;
            else if ((gx < 0) == (gy < 0)) dir = 1;
            else                          dir = 3;
        end
    endfunction

    task automatic make_img(input int f, input int kind);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[f][r][c] = 100;
                    1:       img[f][r][c] = (c < W/2) ? 0 : 200;
                    2:       img[f][r][c] = (r == IR && c == IC) ? 40 : 0;
                    default: img[f][r][c] = $urandom_range(255);
                endcase
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1 chk({tag, "_rdy_in_rst"}, in_ready, 0);
        @(negedge clk);
        #1;
        chk({tag, "_vld_rst"},  out_valid, 0);
        chk({tag, "_mag_rst"},  out_mag,   0);
        chk({tag, "_dir_rst"},  out_dir,   0);
        chk({tag, "_last_rst"}, out_last,  0);
        reset = 1'b0;
        #1 chk({tag, "_rdy_fill"}, in_ready, 1);
    endtask

    // drive nf frames back to back; abort_at >= 0 stops after that many inputs
    task automatic run_stream(input string tag, input int nf, input int rdy_pct,
                              input int gap_pct, input int abort_at);
        int n_in, in_idx, out_idx, cyc, lasts, budget, lim, f, pos, em, ed;
        n_in = nf * NPX; in_idx = 0; out_idx = 0; cyc = 0; lasts = 0;
        budget = n_in * 8 + 200;
        lim = (abort_at >= 0) ? abort_at : n_in;
        while (cyc < budget) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < rdy_pct);
            if (in_idx < lim && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_pixel = DW'(img[in_idx / NPX][(in_idx % NPX) / W][in_idx % W]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_idx < n_in) begin
                f = out_idx / NPX; pos = out_idx % NPX;
                ref_px(f, pos / W, pos % W, em, ed);
                chk({tag, "_mag"},  out_mag,  em);
                chk({tag, "_dir"},  out_dir,  ed);
                chk({tag, "_last"}, out_last, (pos == NPX-1) ? 1 : 0);
                if (out_ready) begin
                    cap_mag[f][pos] = out_mag;
                    cap_dir[f][pos] = out_dir;
                    if (out_last) lasts++;
                    out_idx++;
                end
            end
            if (in_valid && in_ready) in_idx++;
            cyc++;
            if (abort_at >= 0 ? (in_idx >= abort_at) : (out_idx >= n_in)) break;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (abort_at < 0) begin
            chk({tag, "_count"}, out_idx, n_in);
            chk({tag, "_lasts"}, lasts,   nf);
        end else begin
            chk({tag, "_accepted"}, in_idx, abort_at);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        do_reset("init");

        make_img(0, 0);
        run_stream("flat", 1, 100, 0, -1);

        make_img(0, 1);
        run_stream("step", 1, 100, 0, -1);
        chk("step_edge_l", cap_mag[0][5*W + W/2 - 1], 255);
        chk("step_edge_r", cap_mag[0][5*W + W/2],     255);
        chk("step_edge_dir", cap_dir[0][5*W + W/2],   0);
        chk("step_flat",   cap_mag[0][5*W + W/2 - 2], 0);
        chk("step_border", cap_mag[0][W/2],           0);

        make_img(0, 2);
        run_stream("imp", 1, 100, 0, -1);
        chk("imp_w_mag",  cap_mag[0][IR*W + IC-1],     80);
        chk("imp_w_dir",  cap_dir[0][IR*W + IC-1],     0);
        chk("imp_n_mag",  cap_mag[0][(IR-1)*W + IC],   80);
        chk("imp_n_dir",  cap_dir[0][(IR-1)*W + IC],   DEN ? 2 : 0);
        chk("imp_nw_mag", cap_mag[0][(IR-1)*W + IC-1], 80);
        chk("imp_nw_dir", cap_dir[0][(IR-1)*W + IC-1], DEN ? 3 : 0);
        chk("imp_ne_mag", cap_mag[0][(IR-1)*W + IC+1], 80);
        chk("imp_ne_dir", cap_dir[0][(IR-1)*W + IC+1], DEN ? 1 : 0);

        make_img(0, 3);
        run_stream("rnd", 1, 100, 0, -1);
        run_stream("rnd_stall", 1, 70, 25, -1);

        make_img(0, 1);
        run_stream("abort", 1, 70, 10, (NPX * 3) / 8);
        do_reset("mid");
        run_stream("step_after_rst", 1, 100, 0, -1);

        make_img(0, 3);
        make_img(1, 3);
        run_stream("b2b", 2, 70, 20, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
